// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and helpers for the data memory and the LSU.
//   mem_size_e       - access size encoding carried on req_size
//   data_mem_state_e - control states of data_mem (CLEAR exists only when
//                      DATA_MEM_CLEAR_EN is defined)
//   access_err()     - flags misaligned accesses and the illegal size
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_ILL = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RESP  = 2'd1
`ifdef DATA_MEM_CLEAR_EN
        ,
        ST_CLEAR = 2'd2
`endif
    } data_mem_state_e;

    // 1 when the access cannot be performed: misaligned half/word or size 3.
    function automatic logic access_err(input mem_size_e sz, input logic [1:0] addr_lo);
        logic err;
        case (sz)
            SZ_B:    err = 1'b0;
            SZ_H:    err = addr_lo[0];
            SZ_W:    err = |addr_lo;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load-data aligner, shared with the LSU.
//   word        in  32 : raw memory word
//   addr_lo     in  2  : byte offset within the word
//   size        in  2  : mem_size_e encoding (byte/half/word)
//   is_unsigned in  1  : zero-extend when 1, sign-extend when 0
//   data        out 32 : selected byte/half moved to bit 0 and extended;
//                        words (and the illegal size) pass through unchanged
module mem_load_align
    import data_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        case (mem_size_e'(size))
            SZ_B:    data = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
            SZ_H:    data = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/data_mem.sv
// data_mem: handshaked byte-lane data memory for the CPU load/store path.
// One request per cycle on req_*, exactly one response per accepted request
// on rsp_* one cycle later. Loads are extended by mem_load_align; misaligned
// or illegal-size accesses respond with rsp_err=1, rsp_rdata=0, no write.
//
// Optional build macro: DATA_MEM_CLEAR_EN - after reset release, sweep the
// array to zero one word per cycle before accepting requests.
//
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid/ready    : request handshake
//   req_we             : 1 store, 0 load
//   req_size           : 0 byte, 1 half, 2 word, 3 illegal
//   req_unsigned       : zero-extend loads when 1
//   req_addr           : byte address (wraps modulo memory size)
//   req_wdata          : LSB-justified store data
//   rsp_valid/ready    : response handshake
//   rsp_rdata, rsp_err : response payload
module data_mem
    import data_mem_pkg::*;
#(
    parameter int MEM_WORDS = 262144,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    data_mem_state_e state;

    logic [31:0]      mem [MEM_WORDS];
    logic [IDX_W-1:0] req_idx;
    logic [1:0]       addr_lo;
    logic             accept;
    logic             req_bad;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic [31:0]      rd_word;
    logic [31:0]      load_val;

    assign req_idx = req_addr[IDX_W+1:2];
    assign addr_lo = req_addr[1:0];

    // Address bits above the array index are ignored (aliasing).
    generate
        if (ADDR_W > IDX_W + 2) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr[ADDR_W-1:IDX_W+2];
        end
    endgenerate

`ifdef DATA_MEM_CLEAR_EN
    logic [IDX_W-1:0] clr_idx;

    // CLEAR holds ready low by itself; reset drives state to CLEAR.
    assign req_ready = (state == ST_IDLE) || ((state == ST_RESP) && rsp_ready);
`else
    // ready_en keeps req_ready low in reset and until the first edge after
    // release, since the FSM already sits in IDLE during reset.
    logic ready_en;

    assign req_ready = ready_en &&
                       ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
`endif

    assign accept  = req_valid && req_ready;
    assign req_bad = access_err(mem_size_e'(req_size), addr_lo);

    // Store lane enables and lane-replicated write data.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = req_wdata;
        case (mem_size_e'(req_size))
            SZ_B: begin
                wr_be   = 4'b0001 << addr_lo;
                wr_data = {4{req_wdata[7:0]}};
            end
            SZ_H: begin
                wr_be   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
            end
            SZ_W:    wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
        if (!(accept && req_we && !req_bad))
            wr_be = 4'b0000;
    end

    // RAM array: per-byte write enables; the write commits on the accept
    // edge so an immediately following load sees it without forwarding.
    always_ff @(posedge clk) begin
`ifdef DATA_MEM_CLEAR_EN
        if (state == ST_CLEAR) begin
            mem[clr_idx] <= '0;
        end else
`endif
        begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b])
                    mem[req_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign rd_word = mem[req_idx];

    mem_load_align u_load_align (
        .word        (rd_word),
        .addr_lo     (addr_lo),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .data        (load_val)
    );

    // Control FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef DATA_MEM_CLEAR_EN
            state   <= ST_CLEAR;
            clr_idx <= '0;
`else
            state    <= ST_IDLE;
            ready_en <= 1'b0;
`endif
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
`ifndef DATA_MEM_CLEAR_EN
            ready_en <= 1'b1;
`endif
            case (state)
`ifdef DATA_MEM_CLEAR_EN
                ST_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (&clr_idx)
                        state <= ST_IDLE;
                end
`endif
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        // A new accept replaces a consumed response directly,
                        // so rsp_valid stays high with no bubble.
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= req_bad;
                        rsp_rdata <= (req_bad || req_we) ? 32'h0 : load_val;
                    end else if ((state == ST_RESP) && rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed self-checking bench for data_mem (MEM_WORDS=16).
module tb_data_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    data_mem #(.MEM_WORDS(16), .ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    // One request/response; caller is at #1 after a rising edge.
    task automatic xfer(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er);
        int n;
        n = 0;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; rsp_ready = 1'b1;
        #1;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            n_total++;
            $display("FAIL xfer_accept_timeout addr=%h got req_ready=%b want 1", addr, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_total++;
        if (rsp_valid !== 1'b1)
            $display("FAIL rsp_latency addr=%h got rsp_valid=%b want 1", addr, rsp_valid);
        else
            n_pass++;
        rd = rsp_rdata;
        er = rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic wait_ready_after_release(input int want_lat);
        int k;
        k = 0;
        rst_n = 1'b1;
        while (k < 100) begin
            @(posedge clk); #1; k++;
            if (req_ready === 1'b1) break;
        end
        n_total++;
        if (k !== want_lat)
            $display("FAIL ready_latency got %0d cycles want %0d", k, want_lat);
        else
            n_pass++;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        logic        er;
        int want_lat;
`ifdef DATA_MEM_CLEAR_EN
        want_lat = 16;
`else
        want_lat = 1;
`endif
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd2;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({req_ready, rsp_valid, rsp_err} !== 3'b000 || rsp_rdata !== 32'h0)
            $display("FAIL reset_outputs got ready=%b valid=%b err=%b rdata=%h want 0 0 0 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        else
            n_pass++;
        wait_ready_after_release(want_lat);
`ifdef DATA_MEM_CLEAR_EN
        xfer(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, rd, er);
        n_total++;
        if (rd !== 32'h0 || er !== 1'b0)
            $display("FAIL clear_load_3c got %h/%b want 00000000/0", rd, er);
        else
            n_pass++;
`endif
    endtask

    task automatic test_word_byte;
        logic [31:0] rd;
        logic        er;
        xfer(1'b1, 2'd2, 1'b0, 32'h8, 32'hDEADBEEF, rd, er);
        n_total++;
        if (rd !== 32'h0 || er !== 1'b0)
            $display("FAIL store_rsp got %h/%b want 00000000/0", rd, er);
        else
            n_pass++;
        xfer(1'b0, 2'd0, 1'b0, 32'hB, 32'h0, rd, er);
        n_total++;
        if (rd !== 32'hFFFFFFDE || er !== 1'b0)
            $display("FAIL lb_signed got %h/%b want ffffffde/0", rd, er);
        else
            n_pass++;
        xfer(1'b0, 2'd0, 1'b1, 32'hB, 32'h0, rd, er);
        n_total++;
        if (rd !== 32'h000000DE || er !== 1'b0)
            $display("FAIL lb_unsigned got %h/%b want 000000de/0", rd, er);
        else
            n_pass++;
        xfer(1'b0, 2'd1, 1'b0, 32'h8, 32'h0, rd, er);
        n_total++;
        if (rd !== 32'hFFFFBEEF)
            $display("FAIL lh_signed got %h want ffffbeef", rd);
        else
            n_pass++;
    endtask

    task automatic test_half;
        logic [31:0] rd;
        logic        er;
        xfer(1'b1, 2'd2, 1'b0, 32'h4, 32'hAAAAAAAA, rd, er);
        xfer(1'b1, 2'd1, 1'b0, 32'h6, 32'hFFFF1234, rd, er);
        xfer(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, er);
        n_total++;
        if (rd !== 32'h1234AAAA || er !== 1'b0)
            $display("FAIL sh_merge got %h/%b want 1234aaaa/0", rd, er);
        else
            n_pass++;
    endtask

    task automatic test_errors;
        logic [31:0] rd;
        logic        er;
        xfer(1'b0, 2'd1, 1'b0, 32'h5, 32'h0, rd, er);
        n_total++;
        if (rd !== 32'h0 || er !== 1'b1)
            $display("FAIL lh_misaligned got %h/%b want 00000000/1", rd, er);
        else
            n_pass++;
        xfer(1'b1, 2'd3, 1'b0, 32'h4, 32'hFFFFFFFF, rd, er);
        n_total++;
        if (rd !== 32'h0 || er !== 1'b1)
            $display("FAIL size3_store got %h/%b want 00000000/1", rd, er);
        else
            n_pass++;
        xfer(1'b1, 2'd2, 1'b0, 32'h6, 32'h0, rd, er);
        n_total++;
        if (rd !== 32'h0 || er !== 1'b1)
            $display("FAIL sw_misaligned got %h/%b want 00000000/1", rd, er);
        else
            n_pass++;
        xfer(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, er);
        n_total++;
        if (rd !== 32'h1234AAAA || er !== 1'b0)
            $display("FAIL err_no_write got %h/%b want 1234aaaa/0", rd, er);
        else
            n_pass++;
    endtask

    task automatic test_alias;
        logic [31:0] rd;
        logic        er;
        xfer(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, rd, er);
        xfer(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er);
        n_total++;
        if (rd !== 32'hCAFEF00D)
            $display("FAIL alias_0x40 got %h want cafef00d", rd);
        else
            n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] addr_v [8];
        logic        we_v   [8];
        logic [31:0] wd_v   [8];
        logic [31:0] exp_v  [8];
        logic [31:0] held;
        logic        holding;
        logic        acc;
        int sent, got, cyc;
        // Alternating store/load to words 10..13: each load follows its store.
        for (int i = 0; i < 4; i++) begin
            addr_v[2*i]   = 32'h28 + 32'(4*i);
            addr_v[2*i+1] = 32'h28 + 32'(4*i);
            we_v[2*i]     = 1'b1;
            we_v[2*i+1]   = 1'b0;
            wd_v[2*i]     = 32'h1111_0000 * 32'(i + 1) + 32'(i);
            wd_v[2*i+1]   = 32'h0;
            exp_v[2*i]    = 32'h0;
            exp_v[2*i+1]  = 32'h1111_0000 * 32'(i + 1) + 32'(i);
        end
        sent = 0; got = 0; cyc = 0; holding = 1'b0; held = '0;
        while ((sent < 8 || got < 8) && cyc < 100) begin
            if (holding) begin
                n_total++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== held)
                    $display("FAIL b2b_hold cyc%0d got %b/%h want 1/%h", cyc, rsp_valid, rsp_rdata, held);
                else
                    n_pass++;
            end
            rsp_ready = !(cyc >= 3 && cyc <= 5);
            if (sent < 8) begin
                req_valid = 1'b1; req_we = we_v[sent]; req_size = 2'd2;
                req_unsigned = 1'b0; req_addr = addr_v[sent]; req_wdata = wd_v[sent];
            end else begin
                req_valid = 1'b0;
            end
            #1;
            holding = 1'b0;
            if (rsp_valid && rsp_ready) begin
                n_total++;
                if (got >= 8 || rsp_rdata !== exp_v[got] || rsp_err !== 1'b0)
                    $display("FAIL b2b_rsp%0d got %h/%b want %h/0", got, rsp_rdata, rsp_err,
                             (got < 8) ? exp_v[got] : 32'hx);
                else
                    n_pass++;
                got++;
            end else if (rsp_valid && !rsp_ready) begin
                n_total++;
                if (req_ready !== 1'b0)
                    $display("FAIL b2b_ready_bp got %b want 0", req_ready);
                else
                    n_pass++;
                holding = 1'b1;
                held = rsp_rdata;
            end
            acc = req_valid && req_ready;
            @(posedge clk); #1;
            if (acc) sent++;
            cyc++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        n_total++;
        if (sent !== 8 || got !== 8 || rsp_valid !== 1'b0)
            $display("FAIL b2b_count got sent=%0d got=%0d valid=%b want 8 8 0", sent, got, rsp_valid);
        else
            n_pass++;
    endtask

    task automatic test_reset_mid;
        int want_lat;
`ifdef DATA_MEM_CLEAR_EN
        want_lat = 16;
`else
        want_lat = 1;
`endif
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h8; req_wdata = '0; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_total++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF)
            $display("FAIL mid_pre got %b/%h want 1/deadbeef", rsp_valid, rsp_rdata);
        else
            n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b0)
            $display("FAIL mid_reset got valid=%b rdata=%h ready=%b want 0 0 0",
                     rsp_valid, rsp_rdata, req_ready);
        else
            n_pass++;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        wait_ready_after_release(want_lat);
    endtask

    initial begin
        test_reset();
        test_word_byte();
        test_half();
        test_errors();
        test_alias();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
